// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT adder results {cout,sum} into one ACC_W-bit total with a sticky overflow flag
module sum_accumulator #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 6,
    parameter int COUNT  = 4,
    parameter int CW     = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic [CW-1:0]     term_cnt
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state_q, state_d;
    logic [ACC_W-1:0] acc_d;
    logic ovf_d;
    logic [CW-1:0] cnt_d, cnt_inc;
    logic [ACC_W:0] term, sum;
    logic accept;
    assign term      = {{(ACC_W - DATA_W){1'b0}}, in_cout, in_sum};
    assign sum       = {1'b0, out_acc} + term;
    assign cnt_inc   = term_cnt + CW'(1);
    assign in_ready  = state_q != HOLD;
    assign out_valid = state_q == HOLD;
    assign accept    = in_valid && in_ready;
    always_comb begin
        state_d = state_q;
        acc_d   = out_acc;
        ovf_d   = out_ovf;
        cnt_d   = term_cnt;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    acc_d   = term[ACC_W-1:0];
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(1);
                    state_d = COUNT == 1 ? HOLD : ACCUM;
                end
                ACCUM: if (accept) begin
                    acc_d   = sum[ACC_W-1:0];
                    ovf_d   = out_ovf | sum[ACC_W];
                    cnt_d   = cnt_inc;
                    state_d = cnt_inc == CW'(COUNT) ? HOLD : ACCUM;
                end
                HOLD: if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_acc  <= '0;
            out_ovf  <= 1'b0;
            term_cnt <= '0;
        end else begin
            state_q  <= state_d;
            out_acc  <= acc_d;
            out_ovf  <= ovf_d;
            term_cnt <= cnt_d;
        end
    end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed and random stimulus against a queue-based batch model
module tb_sum_accumulator;
    localparam int DATA_W = 4, ACC_W = 6, COUNT = 4, CW = $clog2(COUNT + 1);
    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_cout = 0, out_ready = 0;
    logic [DATA_W-1:0] in_sum = '0;
    logic in_ready, out_valid, out_ovf;
    logic [ACC_W-1:0] out_acc;
    logic [CW-1:0] term_cnt;
    int n_chk = 0, n_fail = 0;
    int q[$];

    sum_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_ovf(out_ovf), .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // The batch is the list of accepted terms; total and overflow follow from their plain sum.
    task automatic check_model(string tag);
        int s = 0;
        foreach (q[i]) s += q[i];
        chk({tag, "_valid"}, int'(out_valid), int'(q.size() == COUNT));
        chk({tag, "_ready"}, int'(in_ready), int'(q.size() < COUNT));
        chk({tag, "_cnt"}, int'(term_cnt), q.size());
        chk({tag, "_acc"}, int'(out_acc), s % (1 << ACC_W));
        chk({tag, "_ovf"}, int'(out_ovf), int'(s >= (1 << ACC_W)));
    endtask

    task automatic step(string tag, bit v, int t, bit rdy, bit clr);
        in_valid  = v;
        in_sum    = t[DATA_W-1:0];
        in_cout   = t[DATA_W];
        out_ready = rdy;
        clear     = clr;
        if (clr) q.delete();
        else if (q.size() == COUNT) begin
            if (rdy) q.delete();
        end else if (v) q.push_back(t);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        #1;
        check_model("rst_async");
        @(posedge clk);
        #1;
        check_model("rst");
        #2 rst_n = 1;
        // 1: basic batch
        repeat (4) step("t1", 1, 14, 1, 0);
        chk("t1_total", int'(out_acc), 56);
        chk("t1_ovf_flag", int'(out_ovf), 0);
        step("t1_drain", 0, 0, 1, 0);
        chk("t1_valid_low", int'(out_valid), 0);
        // 2: overflow then flag cleared on next batch
        repeat (4) step("t2", 1, 31, 1, 0);
        chk("t2_total", int'(out_acc), 60);
        chk("t2_ovf_flag", int'(out_ovf), 1);
        step("t2_drain", 1, 31, 1, 0);
        repeat (4) step("t2b", 1, 1, 1, 0);
        chk("t2b_total", int'(out_acc), 4);
        chk("t2b_ovf_flag", int'(out_ovf), 0);
        step("t2b_drain", 0, 0, 1, 0);
        // 3: backpressure
        for (int i = 3; i < 7; i++) step("t3", 1, i, 0, 0);
        repeat (5) step("t3_bp", 1, 9, 0, 0);
        chk("t3_total", int'(out_acc), 18);
        step("t3_rel", 1, 9, 1, 0);
        chk("t3_idle", int'(out_valid), 0);
        // 4: clear drops partial batch and the term presented with it
        step("t4", 1, 5, 1, 0);
        step("t4", 1, 7, 1, 0);
        step("t4_clr", 1, 9, 1, 1);
        chk("t4_cnt_zero", int'(term_cnt), 0);
        repeat (4) step("t4b", 1, 2, 1, 0);
        chk("t4_total", int'(out_acc), 8);
        step("t4_drain", 0, 0, 1, 0);
        // 5: asynchronous reset mid-batch
        step("t5", 1, 7, 1, 0);
        step("t5", 1, 8, 1, 0);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        q.delete();
        check_model("t5_arst");
        @(posedge clk);
        #1;
        check_model("t5_arst_hold");
        #2 rst_n = 1;
        for (int i = 1; i <= 4; i++) step("t5b", 1, i, 1, 0);
        chk("t5_total", int'(out_acc), 10);
        step("t5_drain", 0, 0, 1, 0);
        // 6: gapped input
        for (int i = 0; i < 4; i++) begin
            step("t6", 1, 3, 1, 0);
            if (i < 3) repeat ($urandom_range(0, 3)) step("t6_gap", 0, 0, 1, 0);
        end
        chk("t6_total", int'(out_acc), 12);
        step("t6_drain", 0, 0, 1, 0);
        // random traffic with occasional clears and backpressure
        repeat (400) step("rnd", 1'($urandom), int'($urandom_range(0, 31)),
                          1'($urandom), $urandom_range(0, 19) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
